// File: rtl/cpu_pkg.sv
// Shared definitions for the bit-serial CPU: instruction format, opcodes and
// the program sequencer state encoding.
package cpu_pkg;

   localparam int INST_W = 12;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_LDI  = 4'h1;
   localparam logic [3:0] OP_ADD  = 4'h2;
   localparam logic [3:0] OP_SUB  = 4'h3;
   localparam logic [3:0] OP_AND  = 4'h4;
   localparam logic [3:0] OP_OR   = 4'h5;
   localparam logic [3:0] OP_XOR  = 4'h6;
   localparam logic [3:0] OP_SHL  = 4'h7;
   localparam logic [3:0] OP_SHR  = 4'h8;
   localparam logic [3:0] OP_HALT = 4'hF;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;

   function automatic logic is_halt(input logic [INST_W-1:0] inst);
      return inst[3:0] == OP_HALT;
   endfunction

endpackage

// File: rtl/serial_inst_loader.sv
// Serial-to-parallel instruction assembler: shifts bits in MSB first and
// flags a complete word in the same cycle its last bit is accepted.
module serial_inst_loader
   import cpu_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              en,
   input  logic              bit_in,
   input  logic              bit_valid,
   output logic              word_valid,
   output logic [INST_W-1:0] word,
   output logic              no_partial
);

   localparam int CW = $clog2(INST_W);
   localparam logic [CW-1:0] LAST_BIT = CW'(INST_W - 1);

   logic [INST_W-1:0] shift_q, shift_d;
   logic [CW-1:0]     cnt_q, cnt_d;

   always_comb begin
      shift_d    = shift_q;
      cnt_d      = cnt_q;
      word_valid = 1'b0;
      word       = {shift_q[INST_W-2:0], bit_in};
      if (clr) begin
         shift_d = '0;
         cnt_d   = '0;
      end else if (en && bit_valid) begin
         shift_d = word;
         if (cnt_q == LAST_BIT) begin
            cnt_d      = '0;
            word_valid = 1'b1;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q <= '0;
         cnt_q   <= '0;
      end else begin
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
      end
   end

   assign no_partial = (cnt_q == '0);

endmodule

// File: rtl/prog_sequencer.sv
// Program sequencer: buffers serially loaded instructions and replays them to
// the execution FSM with a start strobe / completion handshake.
module prog_sequencer
   import cpu_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int PW    = $clog2(DEPTH)
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_bit,
   input  logic              load_valid,
   input  logic              clear,
   input  logic              run,
   input  logic              step_mode,
   input  logic              exec_done,
   output logic [INST_W-1:0] inst_out,
   output logic              exec_go,
   output logic [PW-1:0]     pc,
   output logic [PW:0]       prog_len,
   output logic              full,
   output logic              busy,
   output logic              halted,
   output logic              load_err
);

   localparam logic [PW:0] DEPTH_LEN = (PW+1)'(DEPTH);

   logic [1:0]        state_q, state_d;
   logic [PW-1:0]     pc_q, pc_d;
   logic [PW:0]       prog_len_q, prog_len_d;
   logic              halted_q, halted_d;
   logic              load_err_q, load_err_d;
   logic [INST_W-1:0] inst_out_q, inst_out_d;
   logic [INST_W-1:0] mem_q [DEPTH];

   logic              full_w;
   logic              idle_w;
   logic              ld_en;
   logic              word_valid;
   logic [INST_W-1:0] word;
   logic              no_partial;
   logic [PW:0]       pc_inc;
   logic              exec_go_w;

   assign full_w = (prog_len_q == DEPTH_LEN);
   assign idle_w = (state_q == S_IDLE);
   assign ld_en  = idle_w && !full_w && !clear;
   assign pc_inc = {1'b0, pc_q} + (PW+1)'(1);

   serial_inst_loader u_loader (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (clear),
      .en         (ld_en),
      .bit_in     (load_bit),
      .bit_valid  (load_valid),
      .word_valid (word_valid),
      .word       (word),
      .no_partial (no_partial)
   );

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      prog_len_d = prog_len_q;
      halted_d   = halted_q;
      load_err_d = load_err_q;
      inst_out_d = inst_out_q;
      exec_go_w  = 1'b0;
      if (clear) begin
         state_d    = S_IDLE;
         pc_d       = '0;
         prog_len_d = '0;
         halted_d   = 1'b0;
         load_err_d = 1'b0;
      end else begin
         if (load_valid && !ld_en)
            load_err_d = 1'b1;
         if (word_valid)
            prog_len_d = prog_len_q + (PW+1)'(1);
         case (state_q)
            S_IDLE: begin
               // A load bit in the same cycle wins over run.
               if (run && !load_valid && (prog_len_q != '0) &&
                   ({1'b0, pc_q} < prog_len_q) && no_partial) begin
                  state_d    = S_ISSUE;
                  halted_d   = 1'b0;
                  inst_out_d = mem_q[pc_q];
               end
            end
            S_ISSUE: begin
               if (is_halt(inst_out_q)) begin
                  state_d  = S_IDLE;
                  halted_d = 1'b1;
                  pc_d     = '0;
               end else begin
                  exec_go_w = 1'b1;
                  state_d   = S_WAIT;
               end
            end
            S_WAIT: begin
               if (exec_done) begin
                  if (pc_inc == prog_len_q) begin
                     state_d  = S_IDLE;
                     halted_d = 1'b1;
                     pc_d     = '0;
                  end else begin
                     pc_d = pc_inc[PW-1:0];
                     if (step_mode) begin
                        state_d = S_IDLE;
                     end else begin
                        state_d    = S_ISSUE;
                        inst_out_d = mem_q[pc_inc[PW-1:0]];
                     end
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         pc_q       <= '0;
         prog_len_q <= '0;
         halted_q   <= 1'b0;
         load_err_q <= 1'b0;
         inst_out_q <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         prog_len_q <= prog_len_d;
         halted_q   <= halted_d;
         load_err_q <= load_err_d;
         inst_out_q <= inst_out_d;
      end
   end

   // Buffer contents are don't-care after reset, so no reset here.
   always_ff @(posedge clk) begin
      if (word_valid)
         mem_q[prog_len_q[PW-1:0]] <= word;
   end

   assign inst_out = inst_out_q;
   assign exec_go  = exec_go_w;
   assign pc       = pc_q;
   assign prog_len = prog_len_q;
   assign full     = full_w;
   assign busy     = !idle_w;
   assign halted   = halted_q;
   assign load_err = load_err_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed self-checking bench for prog_sequencer.
module tb_prog_sequencer;
   import cpu_pkg::*;

   localparam int DEPTH = 8;
   localparam int PW    = 3;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              load_bit = 1'b0;
   logic              load_valid = 1'b0;
   logic              clear = 1'b0;
   logic              run = 1'b0;
   logic              step_mode = 1'b0;
   logic              exec_done = 1'b0;
   logic [INST_W-1:0] inst_out;
   logic              exec_go;
   logic [PW-1:0]     pc;
   logic [PW:0]       prog_len;
   logic              full;
   logic              busy;
   logic              halted;
   logic              load_err;

   int errors = 0;
   int checks = 0;
   int go_cnt = 0;
   int base;

   prog_sequencer #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_bit   (load_bit),
      .load_valid (load_valid),
      .clear      (clear),
      .run        (run),
      .step_mode  (step_mode),
      .exec_done  (exec_done),
      .inst_out   (inst_out),
      .exec_go    (exec_go),
      .pc         (pc),
      .prog_len   (prog_len),
      .full       (full),
      .busy       (busy),
      .halted     (halted),
      .load_err   (load_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (exec_go) go_cnt++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_word(input logic [INST_W-1:0] w, input logic run_last);
      for (int i = INST_W - 1; i >= 0; i--) begin
         load_bit   = w[i];
         load_valid = 1'b1;
         run        = (i == 0) ? run_last : 1'b0;
         tick();
      end
      load_valid = 1'b0;
      run        = 1'b0;
   endtask

   task automatic pulse_run();
      run = 1'b1;
      tick();
      run = 1'b0;
   endtask

   task automatic done_pulse();
      exec_done = 1'b1;
      tick();
      exec_done = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   task automatic wait_go(input string tag);
      for (int i = 0; i < 40 && !exec_go; i++) tick();
      check(tag, exec_go, 1);
   endtask

   logic [INST_W-1:0] seq3 [3];

   initial begin
      seq3[0] = 12'h010; seq3[1] = 12'h021; seq3[2] = 12'h032;

      // reset values
      tick(); tick();
      check("rst_inst", inst_out, 0);
      check("rst_go", exec_go, 0);
      check("rst_pc", pc, 0);
      check("rst_len", prog_len, 0);
      check("rst_flags", {full, busy, halted, load_err}, 0);
      rst_n = 1'b1;
      tick();

      // single ADD instruction, exec_done 16 cycles after exec_go
      load_word(12'h012, 1'b0);
      check("t1_len", prog_len, 1);
      base = go_cnt;
      pulse_run();
      check("t1_go", exec_go, 1);
      check("t1_inst", inst_out, 12'h012);
      for (int i = 0; i < 16; i++) tick();
      check("t1_busy_wait", busy, 1);
      done_pulse();
      check("t1_halted", halted, 1);
      check("t1_pc", pc, 0);
      check("t1_busy", busy, 0);
      tick();
      check("t1_go_count", go_cnt - base, 1);

      // three instructions, continuous mode, 1-cycle turnaround
      do_clear();
      check("clr_halted", halted, 0);
      for (int k = 0; k < 3; k++) load_word(seq3[k], 1'b0);
      check("t2_len", prog_len, 3);
      base = go_cnt;
      pulse_run();
      for (int k = 0; k < 3; k++) begin
         check($sformatf("t2_go%0d", k), exec_go, 1);
         check($sformatf("t2_inst%0d", k), inst_out, 32'(seq3[k]));
         tick(); tick(); tick();
         done_pulse();
      end
      check("t2_halted", halted, 1);
      check("t2_busy", busy, 0);
      tick();
      check("t2_go_count", go_cnt - base, 3);

      // HALT in the middle stops the run
      do_clear();
      load_word(12'h010, 1'b0);
      load_word(12'h00F, 1'b0);
      load_word(12'h032, 1'b0);
      base = go_cnt;
      pulse_run();
      check("t3_inst0", inst_out, 12'h010);
      tick(); tick();
      done_pulse();
      check("t3_halt_nogo", exec_go, 0);
      check("t3_halt_busy", busy, 1);
      tick();
      check("t3_halted", halted, 1);
      check("t3_pc", pc, 0);
      tick(); tick();
      check("t3_go_count", go_cnt - base, 1);

      // step mode, two instructions
      do_clear();
      step_mode = 1'b1;
      load_word(12'h021, 1'b0);
      load_word(12'h032, 1'b0);
      pulse_run();
      check("t4_inst0", inst_out, 12'h021);
      tick();
      done_pulse();
      check("t4_idle", busy, 0);
      check("t4_pc1", pc, 1);
      check("t4_not_halted", halted, 0);
      pulse_run();
      check("t4_go1", exec_go, 1);
      check("t4_inst1", inst_out, 12'h032);
      tick();
      done_pulse();
      check("t4_halted", halted, 1);
      check("t4_pc0", pc, 0);
      step_mode = 1'b0;

      // clear aborts a run
      pulse_run();
      check("t4b_go", exec_go, 1);
      check("t4b_halted_clr", halted, 0);
      tick();
      clear = 1'b1;
      #1 check("t4b_clear_go", exec_go, 0);
      tick();
      clear = 1'b0;
      check("t4b_busy", busy, 0);
      check("t4b_len", prog_len, 0);

      // fill, overflow, clear
      for (int k = 0; k < DEPTH; k++) load_word(12'(k * 16 + 1), 1'b0);
      check("t5_full", full, 1);
      check("t5_len8", prog_len, 8);
      check("t5_no_err", load_err, 0);
      load_word(12'h055, 1'b0);
      check("t5_err", load_err, 1);
      check("t5_len_stay", prog_len, 8);
      do_clear();
      check("t5_clr_len", prog_len, 0);
      check("t5_clr_full", full, 0);
      check("t5_clr_err", load_err, 0);

      // run with the final load bit: bit taken, run ignored
      load_word(12'h012, 1'b1);
      check("t6_len", prog_len, 1);
      check("t6_busy", busy, 0);
      tick();
      check("t6_busy2", busy, 0);

      // async reset during WAIT
      base = go_cnt;
      pulse_run();
      wait_go("t7_go");
      tick(); tick();
      check("t7_wait_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      check("t7_rst_go", exec_go, 0);
      check("t7_rst_busy", busy, 0);
      check("t7_rst_len", prog_len, 0);
      check("t7_rst_inst", inst_out, 0);
      #3 rst_n = 1'b1;
      tick();
      done_pulse();
      tick(); tick();
      check("t7_no_go", go_cnt - base, 1);
      check("t7_busy_after", busy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
